// File: rtl/rf_stream_pkg.sv
// Shared constants and FSM state type for the register-file stream reader.
// Optional beat marker enabled by RF_STREAM_LAST_EN.
package rf_stream_pkg;

  localparam int WIDTH   = 16;
  localparam int ENTRIES = 16;
  localparam int ADDR_W  = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/rf_addr_counter.sv
// Loadable wrapping read address plus remaining-beat counter.
// RF_STREAM_LAST_EN adds a flag marking one beat left.
module rf_addr_counter
  import rf_stream_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              init,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] addr,
`ifdef RF_STREAM_LAST_EN
  output logic              last,
`endif
  output logic              zero
);

  logic [ADDR_W:0] remaining;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (init) begin
      addr      <= base_addr;
      remaining <= count;
    end else if (step) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign zero = (remaining == '0);

`ifdef RF_STREAM_LAST_EN
  assign last = (remaining == (ADDR_W+1)'(1));
`endif

endmodule

// File: rtl/rf_stream_reader.sv
// Burst read sequencer: walks RF entries and streams them on valid/ready.
// RF_STREAM_LAST_EN adds out_last on the final beat.
module rf_stream_reader
  import rf_stream_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] address_R,
  input  logic [WIDTH-1:0]  RF_out,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef RF_STREAM_LAST_EN
  output logic              out_last,
`endif
  output logic              busy,
  output logic              done
);

  state_t state, state_nxt;
  logic   init, load, accept, zero;

`ifdef RF_STREAM_LAST_EN
  logic last;
`endif

  rf_addr_counter u_cnt (
    .clock     (clock),
    .reset_n   (reset_n),
    .init      (init),
    .step      (load),
    .base_addr (base_addr),
    .count     (count),
    .addr      (address_R),
`ifdef RF_STREAM_LAST_EN
    .last      (last),
`endif
    .zero      (zero)
  );

  assign accept = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    init      = 1'b0;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        init = start;
        if (start)
          state_nxt = (count == '0) ? DONE : STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        // refill the output register whenever it is empty or draining
        load = !zero && (!out_valid || out_ready);
        if (zero && accept)
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= RF_out;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RF_STREAM_LAST_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    out_last <= 1'b0;
    else if (load)   out_last <= last;
    else if (accept) out_last <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_rf_stream_reader.sv
// Directed table-driven bench for rf_stream_reader.
// Build with RF_STREAM_LAST_EN to also check out_last.
module tb_rf_stream_reader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  base_addr = '0;
  logic [4:0]  count = '0;
  logic [3:0]  address_R;
  logic [15:0] RF_out;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
`ifdef RF_STREAM_LAST_EN
  logic        out_last;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  assign RF_out = {12'hA00, address_R};

  rf_stream_reader dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .address_R (address_R),
    .RF_out    (RF_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef RF_STREAM_LAST_EN
    .out_last  (out_last),
`endif
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [3:0]  base;
    logic [4:0]  cnt;
    logic [15:0] ready;
    bit          restart;
    logic [15:0] first;
    logic [15:0] last;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    int nbeat = 0;
    int ndone = 0;
    int nbusy = 0;
    int nvalid = 0;
    int first_v = -1;
    int first_a = -1;
    int last_a = -1;
    logic stall = 1'b0;
    logic [15:0] held = '0;
    logic [15:0] got_first = '0;
    logic [15:0] got_last = '0;
    logic [3:0] a;
    start = 1'b1;
    base_addr = v.base;
    count = v.cnt;
    out_ready = v.ready[0];
    @(posedge clock);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clock);
      start = v.restart && (cyc == 3);
      if (start) begin
        base_addr = 4'd2;
        count = 5'd3;
      end
      if (stall) begin
        chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
        chk({tag, " hold data"}, 32'(out_data), 32'(held));
      end
      if (out_valid && first_v < 0) first_v = cyc;
      nvalid += int'(out_valid);
      ndone += int'(done);
      nbusy += int'(busy);
      out_ready = v.ready[cyc % 16];
      if (out_valid && out_ready) begin
        a = v.base + 4'(nbeat);
        chk({tag, " beat data"}, 32'(out_data), {16'h0, 12'hA00, a});
`ifdef RF_STREAM_LAST_EN
        chk({tag, " out_last"}, 32'(out_last),
            32'(nbeat == int'(v.cnt) - 1));
`endif
        if (nbeat == 0) got_first = out_data;
        got_last = out_data;
        if (first_a < 0) first_a = cyc;
        last_a = cyc;
        nbeat++;
      end
      stall = out_valid && !out_ready;
      held = out_data;
    end
    start = 1'b0;
    chk({tag, " beats"}, 32'(nbeat), 32'(v.cnt));
    chk({tag, " done pulses"}, 32'(ndone), 32'd1);
    chk({tag, " first"}, 32'(got_first), 32'(v.first));
    chk({tag, " last"}, 32'(got_last), 32'(v.last));
    chk({tag, " busy end"}, 32'(busy), 32'd0);
    chk({tag, " valid end"}, 32'(out_valid), 32'd0);
    if (v.cnt == 0) begin
      chk({tag, " busy never"}, 32'(nbusy), 32'd0);
      chk({tag, " valid never"}, 32'(nvalid), 32'd0);
    end else begin
      chk({tag, " first valid cyc"}, 32'(first_v), 32'd2);
      if (v.ready == 16'hFFFF)
        chk({tag, " throughput"}, 32'(last_a - first_a),
            32'(int'(v.cnt) - 1));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " address_R"}, 32'(address_R), 32'd0);
    chk({tag, " out_data"}, 32'(out_data), 32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
`ifdef RF_STREAM_LAST_EN
    chk({tag, " out_last"}, 32'(out_last), 32'd0);
`endif
  endtask

  initial begin
    int nb;
    vec_t v;
    vecs[0] = '{4'd0,  5'd16, 16'hFFFF, 1'b0, 16'hA000, 16'hA00F};
    vecs[1] = '{4'd14, 5'd4,  16'hFFFF, 1'b0, 16'hA00E, 16'hA001};
    vecs[2] = '{4'd3,  5'd5,  16'h9999, 1'b0, 16'hA003, 16'hA007};
    vecs[3] = '{4'd0,  5'd0,  16'hFFFF, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{4'd8,  5'd6,  16'hFFFF, 1'b1, 16'hA008, 16'hA00D};
    vecs[5] = '{4'd15, 5'd1,  16'hAAAA, 1'b0, 16'hA00F, 16'hA00F};

    #2;
    chk_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk_zero("idle");

    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i], $sformatf("vec%0d", i));
      @(negedge clock);
    end

    start = 1'b1;
    base_addr = 4'd0;
    count = 5'd8;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    nb = 0;
    for (int c = 0; c < 20 && nb < 2; c++) begin
      if (out_valid) nb++;
      if (nb < 2) @(negedge clock);
    end
    chk("rst wait beats", 32'(nb), 32'd2);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 chk_zero("async rst");
    @(posedge clock);
    #1 chk_zero("rst held");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    v = '{4'd5, 5'd2, 16'hFFFF, 1'b0, 16'hA005, 16'hA006};
    run_burst(v, "post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
